tl_error_sink: RTL and testbench
================================

// Module: tl_error_sink
// PURPOSE
// TileLink device that terminates requests to addresses no real device claims. It is attached to a
// spare device link of the IO socket (tl_socket_1n), downstream of the socket's address decoder.
// Every request is fully consumed and answered with denied=1, so a stray CPU or DMA access raises a
// bus error instead of hanging the interconnect. Handles one request at a time, including multi-beat
// bursts.
// PARAMETERS
// DataWidth    64  data bus width in bits; power of two, >= 32
// AddrWidth    38  address width; address is ignored
// SourceWidth  5   A/D source id width
// SinkWidth    1   D sink id width; d_sink is driven to 0
// MaxSize      6   largest supported log2(bytes) of a request
// PORTS
// clk_i          in   1     single clock
// rst_ni         in   1     asynchronous, active-low reset
// link_a_ready   out  1     A channel ready
// link_a_valid   in   1     A channel valid
// link_a         in   A     tl_a_t struct (DataWidth/AddrWidth/SourceWidth); opcode, size, source used
// link_b_ready   in   1     ignored
// link_b_valid   out  1     tied 0
// link_b         out  B     tied '0
// link_c_ready   out  1     tied 1 (sinks stray beats)
// link_c_valid   in   1     ignored
// link_c         in   C     ignored
// link_d_ready   in   1     D channel ready
// link_d_valid   out  1     D channel valid
// link_d         out  D     tl_d_t struct: opcode/param/size/source/sink/denied/corrupt/data
// link_e_ready   out  1     tied 1
// link_e_valid   in   1     ignored
// link_e         in   E     ignored
// BEHAVIOUR
// - Width rules: Off = log2(DataWidth/8). beats(size) = (size > Off) ? 1 << (size - Off) : 1.
//   The beat counter is max(1, MaxSize - Off) bits wide and counts down to 0.
// - States: IDLE, DRAIN, RESP. Reset puts the FSM in IDLE.
// - Reset values: link_a_ready=0, link_d_valid=0, and all captured fields =0.
// - IDLE: a_ready=1. An accepted A beat latches opcode, size and source.
//   - PutFull/PutPartial with beats>1: counter=beats-2, go to DRAIN.
//   - Any other opcode: counter = beats-1 for Get/Arithmetic/Logical, 0 otherwise; go to RESP.
// - DRAIN: a_ready=1. Each accepted beat decrements the counter. When a beat is accepted with
//   counter==0, go to RESP.
// - RESP: a_ready=0, d_valid=1. The D fields are registered, so the first D beat appears the cycle
//   after the last A beat.
//   - Get/Arithmetic/Logical: AccessAckData, denied=1, corrupt=1, data=0. Emit counter+1 beats;
//     decrement the counter on each d_valid&&d_ready.
//   - PutFull/PutPartial: one AccessAck beat, denied=1, corrupt=0.
//   - Intent: one HintAck beat, denied=1.
//   - All responses: d_param=0, d_size=latched size, d_source=latched source, d_sink=0.
//   - When the final beat handshakes, go to IDLE. a_ready rises the following cycle; there is no
//     same-cycle overlap.
// - D channel: d_valid and all D fields stay stable while d_ready=0. d_ready held low stalls the
//   block indefinitely.
// - Illegal input: an Acquire opcode or size>MaxSize is a protocol violation. It is flagged by a
//   simulation assertion and treated as Get.
// - Reset mid-burst: asserting rst_ni drops d_valid and a_ready asynchronously. Partial beats are
//   discarded; the host is reset by the same rst_ni.
// STRUCTURE
// - Opcode enums and the tl_a_t/tl_d_t types come from the shared TileLink package.
// - A function tl_beats(size, DataWidth) is added to that package for reuse by adapters.
// - No sub-module: one FSM plus a field register.
// TESTING
// 1 Get size=3, source=5 -> 1 AccessAckData beat, denied=1, corrupt=1, source=5, d_valid at T+1.
// 2 Get size=6 (64-bit bus) -> 8 AccessAckData beats, all denied; a_ready=0 until the 8th beat
//   handshakes.
// 3 PutFull size=6, 8 A beats with random valid gaps -> a_ready=1 throughout the burst, then exactly
//   1 AccessAck denied=1.
// 4 d_ready=0 for 10 cycles during a Get size=5 -> D fields stable; 4 beats total delivered.
// 5 Back-to-back Intent then PutPartial size=2 -> HintAck then AccessAck, sources preserved in order.
// 6 rst_ni pulsed low at beat 3 of a Get size=6 -> d_valid=0 immediately; IDLE with a_ready=1 after
//   release.

Source files
------------

// File: rtl/tl_error_sink_pkg.sv
// ---------------------------------------------------------------------------
// tl_error_sink_pkg: TileLink channel types, opcodes and beat-count helper.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tl_error_sink_pkg;

    localparam int unsigned TL_DW    = 64;
    localparam int unsigned TL_AW    = 38;
    localparam int unsigned TL_SRCW  = 5;
    localparam int unsigned TL_SINKW = 1;
    localparam int unsigned TL_SZW   = 4;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        ArithmeticData = 3'h2,
        LogicalData    = 3'h3,
        Get            = 3'h4,
        Intent         = 3'h5,
        AcquireBlock   = 3'h6,
        AcquirePerm    = 3'h7
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1,
        HintAck       = 3'h2,
        Grant         = 3'h4,
        GrantData     = 3'h5,
        ReleaseAck    = 3'h6
    } tl_d_op_e;

    typedef struct packed {
        tl_a_op_e              opcode;
        logic [2:0]            param;
        logic [TL_SZW-1:0]     size;
        logic [TL_SRCW-1:0]    source;
        logic [TL_AW-1:0]      address;
        logic [TL_DW/8-1:0]    mask;
        logic                  corrupt;
        logic [TL_DW-1:0]      data;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]            opcode;
        logic [1:0]            param;
        logic [TL_SZW-1:0]     size;
        logic [TL_SRCW-1:0]    source;
        logic [TL_AW-1:0]      address;
        logic [TL_DW/8-1:0]    mask;
        logic                  corrupt;
        logic [TL_DW-1:0]      data;
    } tl_b_t;

    typedef struct packed {
        logic [2:0]            opcode;
        logic [2:0]            param;
        logic [TL_SZW-1:0]     size;
        logic [TL_SRCW-1:0]    source;
        logic [TL_AW-1:0]      address;
        logic                  corrupt;
        logic [TL_DW-1:0]      data;
    } tl_c_t;

    typedef struct packed {
        tl_d_op_e              opcode;
        logic [1:0]            param;
        logic [TL_SZW-1:0]     size;
        logic [TL_SRCW-1:0]    source;
        logic [TL_SINKW-1:0]   sink;
        logic                  denied;
        logic                  corrupt;
        logic [TL_DW-1:0]      data;
    } tl_d_t;

    typedef struct packed {
        logic [TL_SINKW-1:0]   sink;
    } tl_e_t;

    // Number of data beats a transfer of 2**size bytes occupies on a data_width-bit bus.
    function automatic int unsigned tl_beats(input logic [TL_SZW-1:0] size,
                                             input int unsigned       data_width);
        int unsigned off;
        off = $clog2(data_width / 8);
        return (32'(size) > off) ? (32'd1 << (32'(size) - off)) : 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tl_error_sink.sv
// ---------------------------------------------------------------------------
// tl_error_sink: consumes every TileLink request and answers it with denied=1.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tl_error_sink
    import tl_error_sink_pkg::*;
#(
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned AddrWidth   = 38,
    parameter int unsigned SourceWidth = 5,
    parameter int unsigned SinkWidth   = 1,
    parameter int unsigned MaxSize     = 6
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    output logic   link_a_ready,
    input  logic   link_a_valid,
    input  tl_a_t  link_a,
    input  logic   link_b_ready,
    output logic   link_b_valid,
    output tl_b_t  link_b,
    output logic   link_c_ready,
    input  logic   link_c_valid,
    input  tl_c_t  link_c,
    input  logic   link_d_ready,
    output logic   link_d_valid,
    output tl_d_t  link_d,
    output logic   link_e_ready,
    input  logic   link_e_valid,
    input  tl_e_t  link_e
);

    localparam int unsigned Off  = $clog2(DataWidth / 8);
    localparam int unsigned CntW = (MaxSize > Off + 1) ? (MaxSize - Off) : 1;
    localparam bit ParamsOk = (DataWidth == TL_DW) && (AddrWidth == TL_AW) &&
                              (SourceWidth == TL_SRCW) && (SinkWidth == TL_SINKW) &&
                              (DataWidth >= 32) && (MaxSize < 16);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StResp  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    tl_a_op_e               opcode_q, opcode_d;
    logic [TL_SZW-1:0]      size_q, size_d;
    logic [SourceWidth-1:0] source_q, source_d;
    logic                   a_ready_q, a_ready_d;
    logic                   d_valid_q, d_valid_d;

    logic                   a_hs, d_hs;
    logic                   size_illegal, illegal_req;
    tl_a_op_e               eff_op;
    logic [TL_SZW-1:0]      eff_size;
    int unsigned            beats;

    function automatic logic is_data_op(input tl_a_op_e op);
        return op inside {Get, ArithmeticData, LogicalData};
    endfunction

    function automatic logic is_put_op(input tl_a_op_e op);
        return op inside {PutFullData, PutPartialData};
    endfunction

    assign a_hs = link_a_valid && a_ready_q;
    assign d_hs = d_valid_q && link_d_ready;

    // Acquires and oversized requests are answered as a maximal-size-clamped Get.
    assign size_illegal = 32'(link_a.size) > MaxSize;
    assign illegal_req  = size_illegal || (link_a.opcode inside {AcquireBlock, AcquirePerm});
    assign eff_op       = illegal_req ? Get : link_a.opcode;
    assign eff_size     = size_illegal ? TL_SZW'(MaxSize) : link_a.size;
    assign beats        = tl_beats(eff_size, DataWidth);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opcode_d  = opcode_q;
        size_d    = size_q;
        source_d  = source_q;
        a_ready_d = a_ready_q;
        d_valid_d = d_valid_q;
        case (state_q)
            StIdle: begin
                a_ready_d = 1'b1;
                if (a_hs) begin
                    opcode_d = eff_op;
                    size_d   = link_a.size;
                    source_d = link_a.source;
                    if (is_put_op(eff_op) && beats > 1) begin
                        cnt_d   = CntW'(beats - 32'd2);
                        state_d = StDrain;
                    end else begin
                        cnt_d     = is_data_op(eff_op) ? CntW'(beats - 32'd1) : '0;
                        state_d   = StResp;
                        a_ready_d = 1'b0;
                        d_valid_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                a_ready_d = 1'b1;
                if (a_hs) begin
                    if (cnt_q == '0) begin
                        state_d   = StResp;
                        a_ready_d = 1'b0;
                        d_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            StResp: begin
                a_ready_d = 1'b0;
                d_valid_d = 1'b1;
                if (d_hs) begin
                    if (cnt_q == '0) begin
                        state_d   = StIdle;
                        d_valid_d = 1'b0;
                        a_ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                a_ready_d = 1'b0;
                d_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            opcode_q  <= PutFullData;
            size_q    <= '0;
            source_q  <= '0;
            a_ready_q <= 1'b0;
            d_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opcode_q  <= opcode_d;
            size_q    <= size_d;
            source_q  <= source_d;
            a_ready_q <= a_ready_d;
            d_valid_q <= d_valid_d;
        end
    end

    // D fields depend only on captured state, so they hold steady under backpressure.
    always_comb begin
        link_d         = '0;
        link_d.opcode  = is_data_op(opcode_q) ? AccessAckData :
                         (opcode_q == Intent)  ? HintAck : AccessAck;
        link_d.param   = '0;
        link_d.size    = size_q;
        link_d.source  = source_q;
        link_d.sink    = '0;
        link_d.denied  = 1'b1;
        link_d.corrupt = is_data_op(opcode_q);
        link_d.data    = '0;
    end

    assign link_a_ready = a_ready_q;
    assign link_d_valid = d_valid_q;
    assign link_b_valid = 1'b0;
    assign link_b       = '0;
    assign link_c_ready = 1'b1;
    assign link_e_ready = 1'b1;

    logic unused_inputs;
    assign unused_inputs = ^{link_b_ready, link_c_valid, link_c, link_e_valid, link_e,
                             link_a.param, link_a.address, link_a.mask, link_a.corrupt,
                             link_a.data};

    a_params_match: assert property (@(posedge clk_i) ParamsOk);
    a_legal_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                      a_hs |-> !illegal_req);

endmodule

`default_nettype wire

// File: tb/tb_tl_error_sink.sv
// ---------------------------------------------------------------------------
// tb_tl_error_sink: randomized self-checking bench for tl_error_sink.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tl_error_sink;
    import tl_error_sink_pkg::*;

    logic  clk_i = 1'b0;
    logic  rst_ni;
    logic  link_a_ready, link_a_valid;
    tl_a_t link_a;
    logic  link_b_ready, link_b_valid;
    tl_b_t link_b;
    logic  link_c_ready, link_c_valid;
    tl_c_t link_c;
    logic  link_d_ready, link_d_valid;
    tl_d_t link_d;
    logic  link_e_ready, link_e_valid;
    tl_e_t link_e;

    always #5 clk_i = ~clk_i;

    tl_error_sink #(
        .DataWidth(64), .AddrWidth(38), .SourceWidth(5), .SinkWidth(1), .MaxSize(6)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .link_a_ready(link_a_ready), .link_a_valid(link_a_valid), .link_a(link_a),
        .link_b_ready(link_b_ready), .link_b_valid(link_b_valid), .link_b(link_b),
        .link_c_ready(link_c_ready), .link_c_valid(link_c_valid), .link_c(link_c),
        .link_d_ready(link_d_ready), .link_d_valid(link_d_valid), .link_d(link_d),
        .link_e_ready(link_e_ready), .link_e_valid(link_e_valid), .link_e(link_e)
    );

    int    checks = 0;
    int    errors = 0;
    tl_d_t got[$];
    tl_d_t exp[$];
    int    a_wait_cycles;
    int    overlap_seen;
    int    unstable_seen;
    bit    timed_out;

    // Reference model: what the bus should see for one request on a 64-bit bus.
    function automatic void model_resp(input logic [2:0] op, input logic [3:0] size,
                                       input logic [4:0] src);
        tl_d_t e;
        int    n;
        bit    is_data;
        is_data   = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
        n         = (is_data && size > 4'd3) ? (1 << (size - 4'd3)) : 1;
        e         = '0;
        e.opcode  = is_data ? AccessAckData : ((op == 3'd5) ? HintAck : AccessAck);
        e.size    = size;
        e.source  = src;
        e.denied  = 1'b1;
        e.corrupt = is_data;
        for (int i = 0; i < n; i++) exp.push_back(e);
    endfunction

    task automatic drive_a(input logic [2:0] op, input logic [3:0] size,
                           input logic [4:0] src, input int max_gap);
        int nb;
        int w;
        nb = (op <= 3'd1 && size > 4'd3) ? (1 << (size - 4'd3)) : 1;
        a_wait_cycles = 0;
        for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                link_a_valid = 1'b0;
                if (b > 0 && !link_a_ready) a_wait_cycles++;
                @(negedge clk_i);
            end
            link_a_valid   = 1'b1;
            link_a.opcode  = tl_a_op_e'(op);
            link_a.param   = '0;
            link_a.size    = size;
            link_a.source  = src;
            link_a.address = {6'd0, $urandom()};
            link_a.mask    = '1;
            link_a.data    = {$urandom(), $urandom()};
            w = 0;
            while (!link_a_ready && w < 200) begin
                @(negedge clk_i);
                w++;
            end
            if (w >= 200) timed_out = 1'b1;
            if (b > 0) a_wait_cycles += w;
            @(negedge clk_i);
        end
        link_a_valid = 1'b0;
    endtask

    task automatic collect(input int ready_pct, input int stall);
        tl_d_t held;
        bit    held_v;
        int    cyc;
        held_v = 1'b0;
        held   = '0;
        cyc    = 0;
        while (!(link_a_ready && !link_d_valid) && cyc < 500) begin
            if (held_v && (!link_d_valid || link_d !== held)) unstable_seen++;
            if (link_a_ready && link_d_valid) overlap_seen++;
            link_d_ready = (cyc >= stall) && ($urandom_range(99, 0) < ready_pct);
            if (link_d_valid && link_d_ready) begin
                got.push_back(link_d);
                held_v = 1'b0;
            end else begin
                held_v = link_d_valid;
                held   = link_d;
            end
            @(negedge clk_i);
            cyc++;
        end
        if (cyc >= 500) timed_out = 1'b1;
        link_d_ready = 1'b0;
    endtask

    task automatic start_scenario();
        got.delete();
        exp.delete();
        overlap_seen  = 0;
        unstable_seen = 0;
        timed_out     = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (link_a_ready !== 1'b0 || link_d_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: a_ready=%b d_valid=%b, required 0 0", link_a_ready, link_d_valid);
        end
        checks++;
        if (link_b_valid !== 1'b0 || link_b !== '0 || link_c_ready !== 1'b1 || link_e_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ties: b_valid=%b c_ready=%b e_ready=%b, required 0 1 1", link_b_valid, link_c_ready, link_e_ready);
        end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if (link_a_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_a_ready: got %b, required 1", link_a_ready);
        end
    endtask

    task automatic test_get_single();
        start_scenario();
        model_resp(3'd4, 4'd3, 5'd5);
        drive_a(3'd4, 4'd3, 5'd5, 0);
        checks++;
        if (link_d_valid !== 1'b1 || link_a_ready !== 1'b0) begin
            errors++;
            $display("FAIL get_single_latency: d_valid=%b a_ready=%b, required 1 0", link_d_valid, link_a_ready);
        end
        collect(100, 0);
        checks++;
        if (got.size() != exp.size() || timed_out) begin
            errors++;
            $display("FAIL get_single_count: got %0d beats, required %0d", got.size(), exp.size());
        end
        foreach (exp[i]) if (i < got.size()) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL get_single_beat%0d: got %h required %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_get_burst();
        start_scenario();
        model_resp(3'd4, 4'd6, 5'd17);
        drive_a(3'd4, 4'd6, 5'd17, 1);
        collect(70, 0);
        checks++;
        if (got.size() != 8 || timed_out) begin
            errors++;
            $display("FAIL get_burst_count: got %0d beats, required 8", got.size());
        end
        checks++;
        if (overlap_seen != 0) begin
            errors++;
            $display("FAIL get_burst_a_ready_low: a_ready high with d_valid %0d times, required 0", overlap_seen);
        end
        foreach (exp[i]) if (i < got.size()) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL get_burst_beat%0d: got %h required %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_put_burst();
        start_scenario();
        model_resp(3'd0, 4'd6, 5'd9);
        drive_a(3'd0, 4'd6, 5'd9, 3);
        checks++;
        if (a_wait_cycles != 0 || timed_out) begin
            errors++;
            $display("FAIL put_burst_a_ready: a_ready low for %0d cycles mid-burst, required 0", a_wait_cycles);
        end
        collect(100, 0);
        checks++;
        if (got.size() != 1) begin
            errors++;
            $display("FAIL put_burst_count: got %0d responses, required 1", got.size());
        end else begin
            checks++;
            if (got[0] !== exp[0]) begin
                errors++;
                $display("FAIL put_burst_resp: got %h required %h", got[0], exp[0]);
            end
        end
    endtask

    task automatic test_stall();
        start_scenario();
        model_resp(3'd4, 4'd5, 5'd3);
        drive_a(3'd4, 4'd5, 5'd3, 0);
        collect(100, 10);
        checks++;
        if (unstable_seen != 0) begin
            errors++;
            $display("FAIL stall_stable: D changed under backpressure %0d times, required 0", unstable_seen);
        end
        checks++;
        if (got.size() != 4 || timed_out) begin
            errors++;
            $display("FAIL stall_count: got %0d beats, required 4", got.size());
        end
        foreach (exp[i]) if (i < got.size()) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL stall_beat%0d: got %h required %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        start_scenario();
        model_resp(3'd5, 4'd4, 5'd21);
        model_resp(3'd1, 4'd2, 5'd7);
        drive_a(3'd5, 4'd4, 5'd21, 0);
        collect(100, 0);
        drive_a(3'd1, 4'd2, 5'd7, 0);
        collect(100, 0);
        checks++;
        if (got.size() != 2 || timed_out) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses, required 2", got.size());
        end
        foreach (exp[i]) if (i < got.size()) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL b2b_resp%0d: got %h required %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        int cyc;
        start_scenario();
        drive_a(3'd4, 4'd6, 5'd11, 0);
        link_d_ready = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 3 && cyc < 50) begin
            if (link_d_valid) n++;
            @(negedge clk_i);
            cyc++;
        end
        checks++;
        if (link_d_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: d_valid=%b before reset, required 1", link_d_valid);
        end
        #2 rst_ni = 1'b0;
        link_d_ready = 1'b0;
        #1;
        checks++;
        if (link_d_valid !== 1'b0 || link_a_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: d_valid=%b a_ready=%b, required 0 0", link_d_valid, link_a_ready);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if (link_a_ready !== 1'b1 || link_d_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: a_ready=%b d_valid=%b, required 1 0", link_a_ready, link_d_valid);
        end
        start_scenario();
        model_resp(3'd4, 4'd3, 5'd2);
        drive_a(3'd4, 4'd3, 5'd2, 0);
        collect(100, 0);
        checks++;
        if (got.size() != 1 || got[0] !== exp[0]) begin
            errors++;
            $display("FAIL rst_mid_recover: got %0d beats first %h, required 1 beat %h", got.size(), (got.size() > 0) ? got[0] : '0, exp[0]);
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [3:0] size;
        logic [4:0] src;
        for (int t = 0; t < 25; t++) begin
            start_scenario();
            op   = 3'($urandom_range(5, 0));
            size = 4'($urandom_range(6, 0));
            src  = 5'($urandom_range(31, 0));
            model_resp(op, size, src);
            drive_a(op, size, src, 2);
            collect(60, $urandom_range(3, 0));
            checks++;
            if (got.size() != exp.size() || timed_out || unstable_seen != 0 || overlap_seen != 0) begin
                errors++;
                $display("FAIL rand%0d_count: op=%0d size=%0d got %0d beats unstable=%0d, required %0d beats stable", t, op, size, got.size(), unstable_seen, exp.size());
            end
            foreach (exp[i]) if (i < got.size()) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d: got %h required %h", t, i, got[i], exp[i]);
                end
            end
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        link_a_valid = 1'b0;
        link_a       = '0;
        link_b_ready = 1'b0;
        link_c_valid = 1'b0;
        link_c       = '0;
        link_d_ready = 1'b0;
        link_e_valid = 1'b0;
        link_e       = '0;
        test_reset();
        test_get_single();
        test_get_burst();
        test_put_burst();
        test_stall();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
